// File: rtl/object_renderer_pkg.sv
// Shared definitions for the object renderer: 640x480 defaults, colours,
// FSM encoding and the saturating hit counter helper.
package object_renderer_pkg;

    localparam int H_PIXELS_DEF = 640;
    localparam int V_PIXELS_DEF = 480;
    localparam int OBJ_SIZE_DEF = 32;
    localparam int STEP_DEF     = 2;
    localparam int START_X_DEF  = 304;
    localparam int START_Y_DEF  = 224;

    // Positions are signed so a move past zero is visible before clamping
    localparam int POS_W = 16;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam rgb_t COLOUR_OBJECT     = 24'hFF_FF_00;
    localparam rgb_t COLOUR_BACKGROUND = 24'h00_00_40;
    localparam rgb_t COLOUR_BLACK      = 24'h00_00_00;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_BOUNCE = 1'b1;

    function automatic logic [15:0] sat_add_hits(input logic [15:0] base, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/object_renderer_if.sv
// Video bundle between the timing generator side and the renderer:
// timing/coordinate inputs and the delayed syncs plus colour outputs.
interface object_renderer_if;

    logic        h_sync_in;
    logic        v_sync_in;
    logic        disp_ena;
    logic [31:0] column;
    logic [31:0] row;
    logic        h_sync;
    logic        v_sync;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    modport master (
        output h_sync_in, v_sync_in, disp_ena, column, row,
        input  h_sync, v_sync, red, green, blue
    );

    modport slave (
        input  h_sync_in, v_sync_in, disp_ena, column, row,
        output h_sync, v_sync, red, green, blue
    );

endinterface

// File: rtl/object_renderer_motion_axis.sv
// One axis of object motion: manual stepping with clamping, or bouncing
// between 0 and bound with direction reversal and a hit pulse.
module motion_axis
    import object_renderer_pkg::*;
#(
    parameter int bound = 608,
    parameter int step  = 2,
    parameter int start = 304
) (
    input  logic                    pixel_clk,
    input  logic                    reset_n,
    input  logic                    frame_tick,
    input  logic                    bounce,
    input  logic                    btn_inc,
    input  logic                    btn_dec,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir_pos,
    output logic                    hit
);

    localparam logic signed [POS_W-1:0] BOUND_S = POS_W'(bound);
    localparam logic signed [POS_W-1:0] STEP_S  = POS_W'(step);
    localparam logic signed [POS_W-1:0] NSTEP_S = -STEP_S;
    localparam logic signed [POS_W-1:0] START_S = POS_W'(start);
    localparam logic signed [POS_W-1:0] ZERO_S  = POS_W'(0);

    logic signed [POS_W-1:0] pos_r;
    logic signed [POS_W-1:0] move_s;
    logic signed [POS_W-1:0] cand_s;
    logic signed [POS_W-1:0] pos_next_s;
    logic                    dir_r;
    logic                    dir_next_s;
    logic                    hit_s;

    // Next position/direction; reaching a bound while bouncing counts as a hit
    always_comb begin
        move_s     = ZERO_S;
        pos_next_s = pos_r;
        dir_next_s = dir_r;
        hit_s      = 1'b0;
        if (bounce) begin
            move_s = dir_r ? STEP_S : NSTEP_S;
        end else if (btn_inc && !btn_dec) begin
            move_s = STEP_S;
        end else if (btn_dec && !btn_inc) begin
            move_s = NSTEP_S;
        end else begin
            move_s = ZERO_S;
        end
        cand_s = pos_r + move_s;
        if (bounce) begin
            if (dir_r && (cand_s >= BOUND_S)) begin
                pos_next_s = BOUND_S;
                dir_next_s = 1'b0;
                hit_s      = 1'b1;
            end else if (!dir_r && (cand_s <= ZERO_S)) begin
                pos_next_s = ZERO_S;
                dir_next_s = 1'b1;
                hit_s      = 1'b1;
            end else begin
                pos_next_s = cand_s;
            end
        end else if (cand_s > BOUND_S) begin
            pos_next_s = BOUND_S;
        end else if (cand_s < ZERO_S) begin
            pos_next_s = ZERO_S;
        end else begin
            pos_next_s = cand_s;
        end
    end

    // Position only moves on the frame tick, keeping it stable while drawing
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            pos_r <= START_S;
            dir_r <= 1'b1;
        end else if (frame_tick) begin
            pos_r <= pos_next_s;
            dir_r <= dir_next_s;
        end else begin
            pos_r <= pos_r;
            dir_r <= dir_r;
        end
    end

    assign pos     = pos_r;
    assign dir_pos = dir_r;
    assign hit     = hit_s & frame_tick;

endmodule

// File: rtl/object_renderer.sv
// Draws a movable square over the incoming video timing; the object is moved
// once per frame, manually by buttons or bouncing off the screen edges.
module object_renderer
    import object_renderer_pkg::*;
#(
    parameter int   h_pixels = H_PIXELS_DEF,
    parameter int   v_pixels = V_PIXELS_DEF,
    parameter int   obj_size = OBJ_SIZE_DEF,
    parameter int   step     = STEP_DEF,
    parameter int   start_x  = START_X_DEF,
    parameter int   start_y  = START_Y_DEF,
    parameter logic h_pol    = 1'b0,
    parameter logic v_pol    = 1'b0
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    object_renderer_if.slave    vid,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                mode,
    output logic [15:0]         hits
);

    localparam logic [31:0] OBJ_SIZE_U = 32'(obj_size);

    logic                    h_sync_r;
    logic                    v_sync_r;
    logic                    v_prev_r;
    logic                    frame_tick_s;
    logic [0:0]              state_r;
    logic [0:0]              state_next_s;
    logic                    bounce_s;
    logic signed [POS_W-1:0] x_s;
    logic signed [POS_W-1:0] y_s;
    logic                    dx_pos_s;
    logic                    dy_pos_s;
    logic                    hit_x_s;
    logic                    hit_y_s;
    logic [1:0]              hit_inc_s;
    logic [15:0]             hits_r;
    logic [31:0]             x_u_s;
    logic [31:0]             y_u_s;
    logic                    inside_s;
    rgb_t                    colour_r;

    // Sync delay line; v_prev_r holds the edge-detect history
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            h_sync_r <= ~h_pol;
            v_sync_r <= ~v_pol;
            v_prev_r <= ~v_pol;
        end else begin
            h_sync_r <= vid.h_sync_in;
            v_sync_r <= vid.v_sync_in;
            v_prev_r <= v_sync_r;
        end
    end

    assign frame_tick_s = (v_sync_r == v_pol) && (v_prev_r != v_pol);
    assign state_next_s = mode ? ST_BOUNCE : ST_MANUAL;
    assign bounce_s     = (state_next_s == ST_BOUNCE);

    // Mode is sampled only at the frame tick
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state_r <= ST_MANUAL;
        end else if (frame_tick_s) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    motion_axis #(.bound(h_pixels - obj_size), .step(step), .start(start_x)) u_axis_x (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick_s),
        .bounce     (bounce_s),
        .btn_inc    (btn_right),
        .btn_dec    (btn_left),
        .pos        (x_s),
        .dir_pos    (dx_pos_s),
        .hit        (hit_x_s)
    );

    motion_axis #(.bound(v_pixels - obj_size), .step(step), .start(start_y)) u_axis_y (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick_s),
        .bounce     (bounce_s),
        .btn_inc    (btn_down),
        .btn_dec    (btn_up),
        .pos        (y_s),
        .dir_pos    (dy_pos_s),
        .hit        (hit_y_s)
    );

    assign hit_inc_s = {1'b0, hit_x_s} + {1'b0, hit_y_s};

    // Wall-bounce counter; a corner adds two in one tick
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            hits_r <= 16'h0000;
        end else begin
            hits_r <= sat_add_hits(hits_r, hit_inc_s);
        end
    end

    // Positions are clamped non-negative, so zero extension is exact
    assign x_u_s    = {{(32 - POS_W){1'b0}}, x_s};
    assign y_u_s    = {{(32 - POS_W){1'b0}}, y_s};
    assign inside_s = (vid.column >= x_u_s) && (vid.column < x_u_s + OBJ_SIZE_U) &&
                      (vid.row >= y_u_s) && (vid.row < y_u_s + OBJ_SIZE_U);

    // Colour register, one cycle behind the coordinates like the syncs
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            colour_r <= COLOUR_BLACK;
        end else if (!vid.disp_ena) begin
            colour_r <= COLOUR_BLACK;
        end else if (inside_s) begin
            colour_r <= COLOUR_OBJECT;
        end else begin
            colour_r <= COLOUR_BACKGROUND;
        end
    end

    assign vid.h_sync = h_sync_r;
    assign vid.v_sync = v_sync_r;
    assign vid.red    = colour_r.red;
    assign vid.green  = colour_r.green;
    assign vid.blue   = colour_r.blue;
    assign hits       = hits_r;

endmodule

// File: tb/tb_object_renderer.sv
// Self-checking bench for object_renderer: short synthetic frames drive the
// motion logic, a scoreboard checks colour and sync delay per pixel.
module tb_object_renderer;
    import object_renderer_pkg::*;

    typedef struct packed {
        logic        h;
        logic        v;
        logic [23:0] rgb;
    } exp_t;

    logic        pixel_clk = 1'b0;
    logic        reset_n;
    logic        btn_up, btn_down, btn_left, btn_right, mode;
    logic [15:0] hits;
    int          checks   = 0;
    int          failures = 0;
    int          exp_x    = 304;
    int          exp_y    = 224;
    exp_t        sb_q[$];

    object_renderer_if vid();

    object_renderer dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .vid       (vid),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .mode      (mode),
        .hits      (hits)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick_clk();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_idle();
        vid.h_sync_in = 1'b1;
        vid.v_sync_in = 1'b1;
        vid.disp_ena  = 1'b0;
        vid.column    = 32'd0;
        vid.row       = 32'd0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        mode = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        tick_clk();
        tick_clk();
        reset_n = 1'b1;
        sb_q.delete();
        exp_x = 304;
        exp_y = 224;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            vid.disp_ena  = 1'b0;
            vid.v_sync_in = 1'b0;
            tick_clk();
            tick_clk();
            vid.v_sync_in = 1'b1;
            tick_clk();
            tick_clk();
        end
    endtask

    // Drive one pixel, push its expected output, then check after the edge
    task automatic drive_pixel(input logic h, input logic v, input logic de, input int col, input int row);
        exp_t e;
        exp_t got;
        vid.h_sync_in = h;
        vid.v_sync_in = v;
        vid.disp_ena  = de;
        vid.column    = 32'(col);
        vid.row       = 32'(row);
        e.h = h;
        e.v = v;
        if (!de) e.rgb = 24'h000000;
        else if (col >= exp_x && col < exp_x + 32 && row >= exp_y && row < exp_y + 32) e.rgb = 24'hFFFF00;
        else e.rgb = 24'h000040;
        sb_q.push_back(e);
        tick_clk();
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e   = sb_q.pop_front();
            got = {vid.h_sync, vid.v_sync, vid.red, vid.green, vid.blue};
            if (got !== e) begin
                failures++;
                $display("FAIL pixel c=%0d r=%0d: got h=%b v=%b rgb=%h required h=%b v=%b rgb=%h",
                         col, row, got.h, got.v, got.rgb, e.h, e.v, e.rgb);
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        vid.h_sync_in = 1'b0;
        vid.v_sync_in = 1'b0;
        vid.disp_ena  = 1'b1;
        reset_n = 1'b0;
        tick_clk();
        tick_clk();
        checks++; if ({vid.red, vid.green, vid.blue} !== 24'h0) begin failures++; $display("FAIL reset_rgb: got %h required 000000", {vid.red, vid.green, vid.blue}); end
        checks++; if ({vid.h_sync, vid.v_sync} !== 2'b11) begin failures++; $display("FAIL reset_sync: got %b required 11", {vid.h_sync, vid.v_sync}); end
        checks++; if (hits !== 16'd0) begin failures++; $display("FAIL reset_hits: got %0d required 0", hits); end
        checks++; if (dut.x_s !== 16'sd304 || dut.y_s !== 16'sd224) begin failures++; $display("FAIL reset_pos: got %0d,%0d required 304,224", dut.x_s, dut.y_s); end
        checks++; if ({dut.dx_pos_s, dut.dy_pos_s, dut.state_r} !== 3'b110) begin failures++; $display("FAIL reset_dir_state: got %b required 110", {dut.dx_pos_s, dut.dy_pos_s, dut.state_r}); end
        reset_n = 1'b1;
        checks++; if (dut.frame_tick_s !== 1'b0) begin failures++; $display("FAIL tick_after_release: got %b required 0", dut.frame_tick_s); end
        tick_clk();
        tick_clk();
        checks++; if (dut.x_s !== 16'sd304) begin failures++; $display("FAIL reset_x_idle: got %0d required 304", dut.x_s); end
        set_idle();
        tick_clk();
        tick_clk();
    endtask

    // Window around the object including its edges, plus a blanked pixel per row
    task automatic test_frame_scan();
        do_reset();
        for (int r = 220; r < 260; r++) begin
            drive_pixel(1'b1, 1'b1, 1'b0, 310, r);
            for (int c = 298; c < 342; c++) begin
                drive_pixel(1'($urandom_range(0, 1)), 1'b1, 1'b1, c, r);
            end
        end
        checks++; if (hits !== 16'd0) begin failures++; $display("FAIL scan_hits: got %0d required 0", hits); end
    endtask

    task automatic test_manual_clamp();
        do_reset();
        btn_right = 1'b1;
        run_frames(200);
        checks++; if (dut.x_s !== 16'sd608) begin failures++; $display("FAIL right_clamp: got %0d required 608", dut.x_s); end
        run_frames(5);
        checks++; if (dut.x_s !== 16'sd608 || hits !== 16'd0) begin failures++; $display("FAIL right_hold: got x=%0d hits=%0d required 608 0", dut.x_s, hits); end
        btn_right = 1'b0;
        btn_left  = 1'b1;
        btn_up    = 1'b1;
        run_frames(400);
        checks++; if (dut.x_s !== 16'sd0 || dut.y_s !== 16'sd0) begin failures++; $display("FAIL low_clamp: got %0d,%0d required 0,0", dut.x_s, dut.y_s); end
        set_idle();
    endtask

    task automatic test_opposing();
        do_reset();
        btn_right = 1'b1;
        run_frames(10);
        checks++; if (dut.x_s !== 16'sd324) begin failures++; $display("FAIL right_10: got %0d required 324", dut.x_s); end
        btn_left = 1'b1;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        run_frames(10);
        checks++; if (dut.x_s !== 16'sd324 || dut.y_s !== 16'sd224) begin failures++; $display("FAIL opposing: got %0d,%0d required 324,224", dut.x_s, dut.y_s); end
        set_idle();
    endtask

    task automatic test_bounce_edge();
        do_reset();
        btn_right = 1'b1;
        run_frames(150);
        checks++; if (dut.x_s !== 16'sd604) begin failures++; $display("FAIL pre_bounce_x: got %0d required 604", dut.x_s); end
        btn_right = 1'b0;
        btn_left  = 1'b1;
        btn_up    = 1'b1;
        mode      = 1'b1;
        run_frames(1);
        checks++; if (dut.x_s !== 16'sd606 || dut.y_s !== 16'sd226 || dut.state_r !== ST_BOUNCE) begin failures++; $display("FAIL bounce_t1: got %0d,%0d st=%b required 606,226 st=1", dut.x_s, dut.y_s, dut.state_r); end
        run_frames(1);
        checks++; if (dut.x_s !== 16'sd608 || dut.dx_pos_s !== 1'b0 || hits !== 16'd1) begin failures++; $display("FAIL bounce_t2: got x=%0d dx=%b hits=%0d required 608 0 1", dut.x_s, dut.dx_pos_s, hits); end
        run_frames(1);
        checks++; if (dut.x_s !== 16'sd606 || dut.y_s !== 16'sd230 || hits !== 16'd1) begin failures++; $display("FAIL bounce_t3: got %0d,%0d hits=%0d required 606,230 1", dut.x_s, dut.y_s, hits); end
        set_idle();
        run_frames(1);
        checks++; if (dut.state_r !== ST_MANUAL || dut.x_s !== 16'sd606) begin failures++; $display("FAIL back_manual: got st=%b x=%0d required 0 606", dut.state_r, dut.x_s); end
    endtask

    task automatic test_corner();
        do_reset();
        btn_right = 1'b1;
        btn_down  = 1'b1;
        run_frames(111);
        btn_down = 1'b0;
        run_frames(40);
        checks++; if (dut.x_s !== 16'sd606 || dut.y_s !== 16'sd446) begin failures++; $display("FAIL pre_corner: got %0d,%0d required 606,446", dut.x_s, dut.y_s); end
        btn_right = 1'b0;
        mode      = 1'b1;
        run_frames(1);
        checks++; if (dut.x_s !== 16'sd608 || dut.y_s !== 16'sd448 || {dut.dx_pos_s, dut.dy_pos_s} !== 2'b00 || hits !== 16'd2) begin
            failures++; $display("FAIL corner: got %0d,%0d dir=%b hits=%0d required 608,448 00 2", dut.x_s, dut.y_s, {dut.dx_pos_s, dut.dy_pos_s}, hits);
        end
        run_frames(1);
        checks++; if (dut.x_s !== 16'sd606 || dut.y_s !== 16'sd446 || hits !== 16'd2) begin failures++; $display("FAIL after_corner: got %0d,%0d hits=%0d required 606,446 2", dut.x_s, dut.y_s, hits); end
        exp_x = 606;
        exp_y = 446;
        drive_pixel(1'b0, 1'b1, 1'b1, 606, 446);
        drive_pixel(1'b0, 1'b1, 1'b1, 605, 446);
        drive_pixel(1'b1, 1'b1, 1'b1, 637, 477);
        drive_pixel(1'b1, 1'b1, 1'b1, 638, 477);
        drive_pixel(1'b1, 1'b1, 1'b1, 637, 478);
        set_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_left = 1'b1;
        run_frames(102);
        btn_left = 1'b0;
        checks++; if (dut.x_s !== 16'sd100) begin failures++; $display("FAIL pre_reset_x: got %0d required 100", dut.x_s); end
        exp_x = 100;
        drive_pixel(1'b1, 1'b1, 1'b1, 110, 230);
        vid.h_sync_in = 1'b0;
        vid.v_sync_in = 1'b0;
        reset_n = 1'b0;
        tick_clk();
        reset_n = 1'b1;
        checks++; if (dut.x_s !== 16'sd304 || dut.state_r !== ST_MANUAL) begin failures++; $display("FAIL mid_reset_state: got x=%0d st=%b required 304 0", dut.x_s, dut.state_r); end
        checks++; if ({vid.red, vid.green, vid.blue} !== 24'h0 || {vid.h_sync, vid.v_sync} !== 2'b11) begin
            failures++; $display("FAIL mid_reset_out: got rgb=%h sync=%b required 000000 11", {vid.red, vid.green, vid.blue}, {vid.h_sync, vid.v_sync});
        end
        exp_x = 304;
        for (int i = 0; i < 24; i++) begin
            drive_pixel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, i, 0);
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_frame_scan();
        test_manual_clamp();
        test_opposing();
        test_bounce_edge();
        test_corner();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/object_renderer.md
OBJECT_RENDERER -- requirements
Module: object_renderer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- h_pixels, 640, visible width
- v_pixels, 480, visible height
- obj_size, 32, square side in pixels
- step, 2, pixels moved per frame
- start_x, 304, reset X
- start_y, 224, reset Y
- h_pol, 1'b0, h_sync polarity
- v_pol, 1'b0, v_sync polarity
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- pixel_clk  in  1  pixel clock, sole clock
- reset_n  in  1  synchronous, active-low reset
- h_sync_in  in  1  horizontal sync from the timing generator
- v_sync_in  in  1  vertical sync from the timing generator
- disp_ena  in  1  visible-area flag from the timing generator
- column  in  32  horizontal pixel coordinate
- row  in  32  vertical pixel coordinate
- btn_up, btn_down, btn_left, btn_right  in  1 each  active-high, already synchronised to pixel_clk
- mode  in  1  0 = manual, 1 = bounce
- h_sync  out  1  h_sync_in delayed 1 cycle
- v_sync  out  1  v_sync_in delayed 1 cycle
- red, green, blue  out  8 each  pixel colour
- hits  out  16  wall-bounce count

Function
REQ-003 frame_tick SHALL be a one-cycle pulse when registered v_sync_in goes from ~v_pol to v_pol; this yields exactly one pulse per frame.
REQ-004 Position (x, y), direction (dx_pos, dy_pos) and state SHALL change only in the cycle after frame_tick; they SHALL be stable during the visible area.
REQ-005 The FSM SHALL have states MANUAL and BOUNCE; mode SHALL be sampled only on frame_tick, and the new state SHALL take effect at that same update.
REQ-006 In MANUAL, x SHALL change by +step for btn_right only and by -step for btn_left only; opposing buttons together SHALL produce no X move. Y SHALL follow the same rule with btn_down (+) and btn_up (-).
REQ-007 All positions SHALL be clamped to [0, h_pixels-obj_size] for X and [0, v_pixels-obj_size] for Y; arithmetic SHALL be signed and at least 12 bits wide, so no wrap-around occurs.
REQ-008 In BOUNCE, each axis SHALL move step in its direction; if the next value crosses a bound, it SHALL be clamped to the bound, its direction inverted, and hits incremented.
REQ-009 In BOUNCE, buttons SHALL be ignored.
REQ-010 A corner hit (both axes reverse on the same tick) SHALL increment hits by 2.
REQ-011 hits SHALL saturate at 16'hFFFF.
REQ-012 Entering BOUNCE SHALL keep the current dx_pos and dy_pos.
REQ-013 inside SHALL be true when x <= column < x+obj_size and y <= row < y+obj_size.
REQ-014 Colour output SHALL be registered with 1-cycle latency:
- disp_ena=0: all channels 0
- disp_ena=1 and inside: object colour FF/FF/00
- otherwise: background colour 00/00/40
REQ-015 h_sync and v_sync SHALL be delayed exactly 1 cycle, so they stay aligned with colour.

Reset
REQ-016 With reset_n=0 at a pixel_clk edge, the block SHALL set:
- x=start_x, y=start_y
- dx_pos=1, dy_pos=1
- state=MANUAL
- hits=0
- red/green/blue=0
- h_sync=~h_pol, v_sync=~v_pol
- frame_tick history cleared
REQ-017 Reset asserted mid-frame SHALL take effect at the next edge, and no frame_tick SHALL be generated in the first cycle after reset release.

Structure
REQ-018 A shared package SHALL hold the 640x480 timing defaults, the colour constants (object, background, black) and the FSM state encoding.
REQ-019 Per-axis move/clamp/bounce logic SHALL be one sub-module, motion_axis, instantiated twice (X and Y). It SHALL take bound, step, buttons and mode, and return position, direction and a hit pulse.

Verification
REQ-020 Reset, then a full frame with no buttons -> object pixels at columns 304..335 and rows 224..255 show FF/FF/00; all others 00/00/40; blanking shows 0; hits=0.
REQ-021 MANUAL, btn_right held for 200 frames -> x=608 (clamped) and stays 608; hits=0.
REQ-022 MANUAL, btn_left+btn_right held 10 frames -> x unchanged.
REQ-023 BOUNCE from x=604, dx_pos=1 -> after 2 ticks x=608, dx_pos=0, hits=1; next tick x=606.
REQ-024 BOUNCE from (606,446) moving +/+ -> next tick (608,448) with both directions inverted and hits incremented by 2.
REQ-025 Pulse reset_n low mid-frame with x=100 -> next cycle x=304, state=MANUAL, colour 0; h_sync/v_sync equal inputs delayed 1 cycle thereafter.
